// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for the programmable clock divider.
interface clk_divider_prog_if #(
    parameter int unsigned CNT_W = 32
);
    logic             en;
    logic [CNT_W-1:0] div_value_in;
    logic             div_load;
    logic             div_busy;
    logic             divided_clk;
    logic             half_tick;
    logic             period_tick;
    logic             running;

    // Requester side: drives run/divisor controls, observes clock and status.
    modport master (
        output en, div_value_in, div_load,
        input  div_busy, divided_clk, half_tick, period_tick, running
    );

    // Divider side.
    modport slave (
        input  en, div_value_in, div_load,
        output div_busy, divided_clk, half_tick, period_tick, running
    );
endinterface

// File: rtl/clk_divider_prog.sv
// Runtime-programmable 50%-duty clock divider / tick generator.
// Divisor changes take effect only at a falling (full-period) boundary, and a
// stop request always lets the current period finish so no runt pulse appears.
module clk_divider_prog #(
    parameter int unsigned      CNT_W     = 32,
    parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(2499999)
) (
    input  logic               clk_in,
    input  logic               rst_n,
    clk_divider_prog_if.slave  bus
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] div_act_q;
    logic [CNT_W-1:0] div_pend_q;
    logic             div_busy_q;
    logic             div_clk_q;
    logic             half_tick_q;
    logic             period_tick_q;
    logic             running_q;

    logic             active_c;
    logic             wrap_c;
    logic             fall_c;
    logic             apply_c;

    // Half-period end, full-period boundary, and when the pending divisor is adopted.
    always_comb begin
        active_c = (state_q == RUN) || (state_q == DRAIN);
        wrap_c   = active_c && (count_q == div_act_q);
        fall_c   = wrap_c && div_clk_q;
        apply_c  = div_busy_q && ((state_q == STOPPED) || fall_c);
    end

    // Counter, output clock, ticks, divisor registers and run/drain/stop FSM.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= STOPPED;
            count_q       <= '0;
            div_act_q     <= DIV_RESET;
            div_pend_q    <= '0;
            div_busy_q    <= 1'b0;
            div_clk_q     <= 1'b0;
            half_tick_q   <= 1'b0;
            period_tick_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            half_tick_q   <= 1'b0;
            period_tick_q <= 1'b0;

            case (state_q)
                STOPPED: begin
                    count_q   <= '0;
                    div_clk_q <= 1'b0;
                    if (bus.en) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (wrap_c) begin
                        count_q     <= '0;
                        div_clk_q   <= ~div_clk_q;
                        half_tick_q <= 1'b1;
                        if (div_clk_q) begin
                            period_tick_q <= 1'b1;
                        end
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end

                    if (state_q == RUN) begin
                        if (!bus.en) begin
                            state_q <= DRAIN;
                        end
                    end else if (bus.en) begin
                        state_q <= RUN;
                    end else if (fall_c) begin
                        state_q   <= STOPPED;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= STOPPED;
                    running_q <= 1'b0;
                end
            endcase

            // Adopt the pending divisor at a boundary or while idle.
            if (apply_c) begin
                div_act_q <= div_pend_q;
            end

            // A fresh load always wins over clearing busy, so it stays pending.
            if (bus.div_load) begin
                div_pend_q <= bus.div_value_in;
                div_busy_q <= 1'b1;
            end else if (apply_c) begin
                div_busy_q <= 1'b0;
            end
        end
    end

    assign bus.div_busy    = div_busy_q;
    assign bus.divided_clk = div_clk_q;
    assign bus.half_tick   = half_tick_q;
    assign bus.period_tick = period_tick_q;
    assign bus.running     = running_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Randomised + directed bench for clk_divider_prog against a phase-countdown reference model.
`timescale 1ns/1ps
module tb_clk_divider_prog;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned DIV_RST   = 3;

    logic clk_in;
    logic rst_n;

    clk_divider_prog_if #(.CNT_W(CNT_W)) bus ();

    clk_divider_prog #(
        .CNT_W     (CNT_W),
        .DIV_RESET (CNT_W'(DIV_RST))
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // 5 MHz board clock.
    initial clk_in = 1'b0;
    always #100 clk_in = ~clk_in;

    int n_tests;
    int n_fail;

    // Reference model: generating flag, stop-requested flag, output level,
    // edges left until next toggle, active/pending divisor.
    bit              m_gen;
    bit              m_stop_req;
    bit              m_lvl;
    int              m_left;
    logic [CNT_W-1:0] m_act;
    logic [CNT_W-1:0] m_pend;
    bit              m_busy;
    bit              m_ht;
    bit              m_pt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gen      = 1'b0;
        m_stop_req = 1'b0;
        m_lvl      = 1'b0;
        m_left     = 0;
        m_act      = CNT_W'(DIV_RST);
        m_pend     = '0;
        m_busy     = 1'b0;
        m_ht       = 1'b0;
        m_pt       = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit e, input bit ld, input logic [CNT_W-1:0] v);
        bit apply;
        bit fell;
        apply = 1'b0;
        fell  = 1'b0;
        m_ht  = 1'b0;
        m_pt  = 1'b0;
        if (!m_gen) begin
            m_lvl = 1'b0;
            if (m_busy) begin
                m_act = m_pend;
                apply = 1'b1;
            end
            if (e) begin
                m_gen      = 1'b1;
                m_stop_req = 1'b0;
                m_left     = int'(m_act) + 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_lvl = !m_lvl;
                m_ht  = 1'b1;
                if (!m_lvl) begin
                    fell = 1'b1;
                    m_pt = 1'b1;
                    if (m_busy) begin
                        m_act = m_pend;
                        apply = 1'b1;
                    end
                end
                m_left = int'(m_act) + 1;
            end
            if (!m_stop_req) begin
                if (!e) m_stop_req = 1'b1;
            end else if (e) begin
                m_stop_req = 1'b0;
            end else if (fell) begin
                m_gen = 1'b0;
            end
        end
        if (ld) begin
            m_pend = v;
            m_busy = 1'b1;
        end else if (apply) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("divided_clk", 32'(bus.divided_clk), 32'(m_lvl));
        check("half_tick",   32'(bus.half_tick),   32'(m_ht));
        check("period_tick", 32'(bus.period_tick), 32'(m_pt));
        check("div_busy",    32'(bus.div_busy),    32'(m_busy));
        check("running",     32'(bus.running),     32'(m_gen));
    endtask

    // Drive at negedge, advance model at posedge, compare at next negedge.
    task automatic step(input bit e, input bit ld, input logic [CNT_W-1:0] v);
        bus.en           = e;
        bus.div_load     = ld;
        bus.div_value_in = v;
        @(posedge clk_in);
        model_edge(e, ld, v);
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(e, 1'b0, '0);
    endtask

    // Step with en held until the divided clock is at the requested level.
    task automatic wait_level(input bit lvl, input bit e);
        int k;
        k = 0;
        while (bus.divided_clk !== lvl && k < 64) begin
            step(e, 1'b0, '0);
            k++;
        end
        if (k >= 64) check("wait_level_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        bit en_r;
        n_tests          = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus.en           = 1'b0;
        bus.div_load     = 1'b0;
        bus.div_value_in = '0;
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        compare_all();
        rst_n = 1'b1;

        // Reset divisor: rise 4 cycles after RUN entry, period 8.
        run(24, 1'b1);

        // Load D=1 during a high phase: high phase stays 4, then halves of 2.
        wait_level(1'b1, 1'b1);
        step(1'b1, 1'b1, CNT_W'(1));
        run(20, 1'b1);

        // Two loads before a boundary: only the last one applies.
        wait_level(1'b1, 1'b1);
        step(1'b1, 1'b1, CNT_W'(5));
        step(1'b1, 1'b1, CNT_W'(2));
        run(30, 1'b1);

        // Back to D=3, then drop en one cycle after a rise: high completes, stop.
        step(1'b1, 1'b1, CNT_W'(3));
        run(16, 1'b1);
        wait_level(1'b0, 1'b1);
        wait_level(1'b1, 1'b1);
        step(1'b0, 1'b0, '0);
        run(12, 1'b0);

        // D=0 loaded while stopped: toggle every cycle once running.
        step(1'b0, 1'b1, CNT_W'(0));
        run(2, 1'b0);
        run(12, 1'b1);

        // Load coincident with a boundary, then stop/restart during drain.
        step(1'b1, 1'b1, CNT_W'(2));
        run(8, 1'b1);
        run(3, 1'b0);
        run(10, 1'b1);

        // Asynchronous reset during a high phase.
        step(1'b1, 1'b1, CNT_W'(4));
        run(12, 1'b1);
        wait_level(1'b1, 1'b1);
        #20;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk_in);
        @(negedge clk_in);
        compare_all();
        rst_n = 1'b1;
        // Reset divisor must be back in force.
        run(20, 1'b1);

        // Randomised run with occasional loads and en toggling.
        en_r = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bit ld;
            if ($urandom_range(0, 19) == 0) en_r = !en_r;
            ld = ($urandom_range(0, 15) == 0);
            step(en_r, ld, CNT_W'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
